seg_frame_sequencer: RTL and testbench
======================================

Name: seg_frame_sequencer

Overview:
- Frame-level controller for the hand-segmentation pixel datapath. It decides, per frame, whether the segmenter runs skin-colour thresholding, background capture or background-difference compare.
- It generates write and read strobes and addresses for the background luma memory (H_ACTIVE*V_ACTIVE entries, synchronous single-cycle read).
- It flags frame-length errors and sits between the camera/colour-conversion front end and the segmentation decision logic.

Parameters:
- H_ACTIVE, 160, active pixels per line.
- V_ACTIVE, 120, active lines per frame.
- ADDR_W, 15, background memory address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse at the start of each frame, before its first pixel.
- pix_valid  in  1  one active pixel presented this cycle.
- bg_diff_req  in  1  level; 1 requests background-difference method, 0 requests skin method.
- recapture  in  1  one-cycle pulse; invalidates the stored background.
- seg_mode  out  2  00 idle, 01 skin, 10 capture, 11 compare; registered.
- bg_we  out  1  background memory write strobe.
- bg_waddr  out  ADDR_W  background write address.
- bg_re  out  1  background memory read strobe.
- bg_raddr  out  ADDR_W  background read address.
- pix_valid_d  out  1  pix_valid delayed by 1 cycle, aligned with bg_we/bg_re.
- bg_valid  out  1  a complete background frame is stored.
- frame_done  out  1  one-cycle pulse after the last pixel (index N-1) of a frame is accepted.
- frame_err  out  1  sticky; set on short or long frame; cleared by rst or recapture.

Behaviour:
- N = H_ACTIVE*V_ACTIVE. pix_cnt is an internal ADDR_W-bit counter.
- Reset state: IDLE. All outputs are 0 and pix_cnt = 0.
- States are IDLE, SKIN, CAPTURE and COMPARE, encoded on seg_mode as above.
- Mode decision happens only when frame_start is seen (in any state):
  - bg_diff_req=0 -> SKIN.
  - bg_diff_req=1 and bg_valid=0 -> CAPTURE.
  - bg_diff_req=1 and bg_valid=1 -> COMPARE.
  - pix_cnt is cleared to 0 at the same time.
  - bg_diff_req changes mid-frame have no effect until the next frame_start.
- In IDLE, pixels are ignored and pix_cnt holds at 0.
- Accepted pixel: pix_valid=1, state != IDLE and pix_cnt < N.
  - pix_cnt increments by 1.
  - One cycle later pix_valid_d=1.
  - In CAPTURE: bg_we=1 and bg_waddr = pre-increment pix_cnt.
  - In COMPARE: bg_re=1 and bg_raddr = pre-increment pix_cnt.
  - In SKIN: both strobes stay 0.
  - Memory read data therefore arrives 2 cycles after pix_valid.
- When the pixel with index N-1 is accepted:
  - frame_done pulses on the next cycle.
  - If in CAPTURE, bg_valid is set on that same cycle.
  - State stays put until the next frame_start.
- Long frame: pix_valid while pix_cnt == N. The pixel is ignored, with no strobes and no pix_valid_d. frame_err is set, pix_cnt holds at N, and no wrap-around occurs.
- Short frame: frame_start while 0 < pix_cnt < N in a non-IDLE state.
  - frame_err is set.
  - If the short frame was a CAPTURE, bg_valid stays 0, so the next frame captures again.
  - The new frame is then decided as normal.
- recapture:
  - Clears bg_valid and frame_err next cycle.
  - In COMPARE it forces state to IDLE at once; the remainder of the frame is dropped.
  - In CAPTURE it also forces IDLE.
  - In SKIN or IDLE only bg_valid and frame_err are affected.
- Simultaneous events:
  - recapture and frame_start together: recapture applies first, so the frame decision sees bg_valid=0.
  - frame_start and pix_valid together: the pixel belongs to the new frame as index 0.
- rst mid-frame returns everything to the reset state next cycle, including bg_valid=0.
- Register pix_cnt is ADDR_W bits wide; the comparison against N uses constant N at ADDR_W+1 bits.

Test Plan:
- Reset, then bg_diff_req=1, then frame_start followed by 19200 pix_valid -> seg_mode=10, bg_we asserted 19200 times with waddr 0..19199, frame_done 1 cycle after the last pixel, bg_valid=1.
- Second frame_start with bg_diff_req=1 and 19200 pixels -> seg_mode=11, bg_re with raddr 0..19199, bg_we never asserted, frame_err=0.
- bg_diff_req=0, then frame_start and 19200 pixels -> seg_mode=01, no strobes, pix_valid_d pulses 19200 times, frame_done once.
- Capture frame cut at 100 pixels by frame_start -> frame_err=1, bg_valid=0, new frame enters CAPTURE again with waddr restarting at 0.
- Compare frame with 19203 pixels -> last 3 pixels produce no bg_re or pix_valid_d, frame_err=1; next recapture clears frame_err and bg_valid and forces seg_mode=00.
- recapture and frame_start in the same cycle with bg_valid=1 and bg_diff_req=1 -> next seg_mode=10; separately, rst at pixel 5000 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/seg_frame_sequencer.sv
// seg_frame_sequencer
//   Per-frame controller for the hand-segmentation pixel datapath. At each
//   frame_start it selects skin thresholding, background capture or
//   background-difference compare. It drives the write/read strobes and
//   addresses of the background luma memory and flags frames whose pixel
//   count is wrong.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   frame_start         one-cycle pulse ahead of a frame's first pixel
//   pix_valid           one active pixel presented this cycle
//   bg_diff_req         level: 1 = background-difference method, 0 = skin
//   recapture           one-cycle pulse: discard the stored background
//   seg_mode            00 idle, 01 skin, 10 capture, 11 compare
//   bg_we / bg_waddr    background memory write strobe / address
//   bg_re / bg_raddr    background memory read strobe / address
//   pix_valid_d         pix_valid delayed one cycle, aligned with strobes
//   bg_valid            a complete background frame is stored
//   frame_done          pulse after the last pixel of a frame is accepted
//   frame_err           sticky short/long frame flag
module seg_frame_sequencer #(
    parameter int unsigned H_ACTIVE = 160,
    parameter int unsigned V_ACTIVE = 120,
    parameter int unsigned ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic              bg_diff_req,
    input  logic              recapture,
    output logic [1:0]        seg_mode,
    output logic              bg_we,
    output logic [ADDR_W-1:0] bg_waddr,
    output logic              bg_re,
    output logic [ADDR_W-1:0] bg_raddr,
    output logic              pix_valid_d,
    output logic              bg_valid,
    output logic              frame_done,
    output logic              frame_err
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_SKIN    = 2'b01;
    localparam logic [1:0] ST_CAPTURE = 2'b10;
    localparam logic [1:0] ST_COMPARE = 2'b11;

    localparam int unsigned     CNT_W  = ADDR_W + 1;
    localparam logic [ADDR_W:0] N_C    = CNT_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [ADDR_W:0] N_LAST = N_C - 1'b1;

    logic [1:0]        state_q,      state_d;
    logic [ADDR_W-1:0] pix_cnt_q,    pix_cnt_d;
    logic              bg_valid_q,   bg_valid_d;
    logic              frame_err_q,  frame_err_d;
    logic              frame_done_q, frame_done_d;
    logic              bg_we_q,      bg_we_d;
    logic              bg_re_q,      bg_re_d;
    logic [ADDR_W-1:0] bg_waddr_q,   bg_waddr_d;
    logic [ADDR_W-1:0] bg_raddr_q,   bg_raddr_d;
    logic              pv_dly_q,     pv_dly_d;

    // Events are applied in priority order on the *_d values: recapture first,
    // then the frame decision, then the pixel, so a pixel arriving with
    // frame_start is index 0 of the new frame.
    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        bg_valid_d   = bg_valid_q;
        frame_err_d  = frame_err_q;
        frame_done_d = 1'b0;
        bg_we_d      = 1'b0;
        bg_re_d      = 1'b0;
        bg_waddr_d   = bg_waddr_q;
        bg_raddr_d   = bg_raddr_q;
        pv_dly_d     = 1'b0;

        if (recapture) begin
            bg_valid_d  = 1'b0;
            frame_err_d = 1'b0;
            if (state_q == ST_CAPTURE || state_q == ST_COMPARE) begin
                state_d   = ST_IDLE;
                pix_cnt_d = '0;
            end
        end

        if (frame_start) begin
            // Short frame: previous frame started but never reached N pixels.
            if (state_d != ST_IDLE && pix_cnt_d != '0 && {1'b0, pix_cnt_d} < N_C)
                frame_err_d = 1'b1;
            if (!bg_diff_req)
                state_d = ST_SKIN;
            else if (bg_valid_d)
                state_d = ST_COMPARE;
            else
                state_d = ST_CAPTURE;
            pix_cnt_d = '0;
        end

        if (pix_valid && state_d != ST_IDLE) begin
            if ({1'b0, pix_cnt_d} < N_C) begin
                pv_dly_d = 1'b1;
                if (state_d == ST_CAPTURE) begin
                    bg_we_d    = 1'b1;
                    bg_waddr_d = pix_cnt_d;
                end
                if (state_d == ST_COMPARE) begin
                    bg_re_d    = 1'b1;
                    bg_raddr_d = pix_cnt_d;
                end
                if ({1'b0, pix_cnt_d} == N_LAST) begin
                    frame_done_d = 1'b1;
                    if (state_d == ST_CAPTURE)
                        bg_valid_d = 1'b1;
                end
                pix_cnt_d = pix_cnt_d + ADDR_W'(1);
            end else begin
                // Long frame: counter parks at N, the pixel is dropped.
                frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pix_cnt_q    <= '0;
            bg_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
            bg_we_q      <= 1'b0;
            bg_re_q      <= 1'b0;
            bg_waddr_q   <= '0;
            bg_raddr_q   <= '0;
            pv_dly_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            bg_valid_q   <= bg_valid_d;
            frame_err_q  <= frame_err_d;
            frame_done_q <= frame_done_d;
            bg_we_q      <= bg_we_d;
            bg_re_q      <= bg_re_d;
            bg_waddr_q   <= bg_waddr_d;
            bg_raddr_q   <= bg_raddr_d;
            pv_dly_q     <= pv_dly_d;
        end
    end

    assign seg_mode    = state_q;
    assign bg_we       = bg_we_q;
    assign bg_waddr    = bg_waddr_q;
    assign bg_re       = bg_re_q;
    assign bg_raddr    = bg_raddr_q;
    assign pix_valid_d = pv_dly_q;
    assign bg_valid    = bg_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg_frame_sequencer.sv
// tb_seg_frame_sequencer
//   Directed frame sequence plus randomized pixel gaps and random event soup,
//   checked every cycle against a frame-level behavioural model and at the end
//   of each directed frame against strobe/address tallies. Frame size is
//   reduced (20x12) to keep run time short.
module tb_seg_frame_sequencer;

    localparam int H  = 20;
    localparam int V  = 12;
    localparam int AW = 9;
    localparam int N  = H * V;

    logic          clk = 1'b0;
    logic          rst, frame_start, pix_valid, bg_diff_req, recapture;
    logic [1:0]    seg_mode;
    logic          bg_we, bg_re, pix_valid_d, bg_valid, frame_done, frame_err;
    logic [AW-1:0] bg_waddr, bg_raddr;

    always #5 clk = ~clk;

    seg_frame_sequencer #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .bg_diff_req (bg_diff_req),
        .recapture   (recapture),
        .seg_mode    (seg_mode),
        .bg_we       (bg_we),
        .bg_waddr    (bg_waddr),
        .bg_re       (bg_re),
        .bg_raddr    (bg_raddr),
        .pix_valid_d (pix_valid_d),
        .bg_valid    (bg_valid),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: mode 0 idle / 1 skin / 2 capture / 3 compare,
    // pixels counted in the current frame, background and error flags.
    int m_mode, m_cnt;
    bit m_bgv, m_err;
    bit e_we, e_re, e_pvd, e_done;
    int e_addr;

    // Tallies of observed DUT activity within one directed frame.
    int ph_we, ph_re, ph_pvd, ph_done, ph_waddr_bad, ph_raddr_bad;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input bit r, input bit fs, input bit pv,
                                  input bit req, input bit rc);
        e_we = 0; e_re = 0; e_pvd = 0; e_done = 0;
        if (r) begin
            m_mode = 0; m_cnt = 0; m_bgv = 0; m_err = 0;
            return;
        end
        if (rc) begin
            m_bgv = 0;
            m_err = 0;
            if (m_mode >= 2) begin m_mode = 0; m_cnt = 0; end
        end
        if (fs) begin
            if (m_mode != 0 && m_cnt > 0 && m_cnt < N) m_err = 1;
            m_mode = !req ? 1 : (m_bgv ? 3 : 2);
            m_cnt  = 0;
        end
        if (pv && m_mode != 0) begin
            if (m_cnt < N) begin
                e_pvd  = 1;
                e_we   = (m_mode == 2);
                e_re   = (m_mode == 3);
                e_addr = m_cnt;
                m_cnt  = m_cnt + 1;
                if (m_cnt == N) begin
                    e_done = 1;
                    if (m_mode == 2) m_bgv = 1;
                end
            end else begin
                m_err = 1;
            end
        end
    endfunction

    task automatic ph_clear();
        ph_we = 0; ph_re = 0; ph_pvd = 0; ph_done = 0;
        ph_waddr_bad = 0; ph_raddr_bad = 0;
    endtask

    task automatic step(input bit r, input bit fs, input bit pv,
                        input bit req, input bit rc);
        rst = r; frame_start = fs; pix_valid = pv;
        bg_diff_req = req; recapture = rc;
        model(r, fs, pv, req, rc);
        @(posedge clk);
        #1;
        chk("seg_mode",    int'(seg_mode),    m_mode);
        chk("bg_we",       int'(bg_we),       int'(e_we));
        chk("bg_re",       int'(bg_re),       int'(e_re));
        chk("pix_valid_d", int'(pix_valid_d), int'(e_pvd));
        chk("frame_done",  int'(frame_done),  int'(e_done));
        chk("bg_valid",    int'(bg_valid),    int'(m_bgv));
        chk("frame_err",   int'(frame_err),   int'(m_err));
        if (e_we) chk("bg_waddr", int'(bg_waddr), e_addr);
        if (e_re) chk("bg_raddr", int'(bg_raddr), e_addr);
        if (bg_we) begin
            if (int'(bg_waddr) != ph_we) ph_waddr_bad++;
            ph_we++;
        end
        if (bg_re) begin
            if (int'(bg_raddr) != ph_re) ph_raddr_bad++;
            ph_re++;
        end
        if (pix_valid_d) ph_pvd++;
        if (frame_done)  ph_done++;
    endtask

    // Sends n pixels with random gaps; bg_diff_req wanders mid-frame.
    task automatic send_pixels(input int n);
        int sent = 0;
        bit pv;
        while (sent < n) begin
            pv = ($urandom_range(0, 3) != 0);
            step(0, 0, pv, 1'($urandom_range(0, 1)), 0);
            if (pv) sent++;
        end
    endtask

    task automatic run_frame(input bit req, input int n);
        ph_clear();
        step(0, 1, 0, req, 0);
        send_pixels(n);
        step(0, 0, 0, req, 0);
        step(0, 0, 0, req, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ph_clear();
        m_mode = 0; m_cnt = 0; m_bgv = 0; m_err = 0; e_addr = 0;

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_seg_mode", int'(seg_mode), 0);
        chk("rst_waddr",    int'(bg_waddr), 0);
        chk("rst_raddr",    int'(bg_raddr), 0);
        chk("rst_bg_valid", int'(bg_valid), 0);
        chk("rst_frame_err", int'(frame_err), 0);

        // Pixels are ignored while idle
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);

        // Capture frame
        run_frame(1, N);
        chk("cap_mode",      int'(seg_mode), 2);
        chk("cap_we_count",  ph_we, N);
        chk("cap_waddr_seq", ph_waddr_bad, 0);
        chk("cap_re_count",  ph_re, 0);
        chk("cap_done",      ph_done, 1);
        chk("cap_bg_valid",  int'(bg_valid), 1);

        // Compare frame
        run_frame(1, N);
        chk("cmp_mode",      int'(seg_mode), 3);
        chk("cmp_re_count",  ph_re, N);
        chk("cmp_raddr_seq", ph_raddr_bad, 0);
        chk("cmp_we_count",  ph_we, 0);
        chk("cmp_err",       int'(frame_err), 0);

        // Skin frame
        run_frame(0, N);
        chk("skin_mode",      int'(seg_mode), 1);
        chk("skin_strobes",   ph_we + ph_re, 0);
        chk("skin_pvd_count", ph_pvd, N);
        chk("skin_done",      ph_done, 1);

        // Recapture in skin only clears background
        step(0, 0, 0, 0, 1);
        chk("rc_skin_mode", int'(seg_mode), 1);
        chk("rc_skin_bgv",  int'(bg_valid), 0);

        // Capture cut at 100 pixels
        ph_clear();
        step(0, 1, 0, 1, 0);
        send_pixels(100);
        ph_clear();
        step(0, 1, 0, 1, 0);
        chk("short_err",  int'(frame_err), 1);
        chk("short_bgv",  int'(bg_valid), 0);
        chk("short_mode", int'(seg_mode), 2);
        send_pixels(N);
        step(0, 0, 0, 1, 0);
        chk("recap_we_count",  ph_we, N);
        chk("recap_waddr_seq", ph_waddr_bad, 0);
        chk("recap_bgv",       int'(bg_valid), 1);

        // Clean background, then a long compare frame
        step(0, 0, 0, 1, 1);
        run_frame(1, N);
        chk("clean_err", int'(frame_err), 0);
        run_frame(1, N + 3);
        chk("long_re_count",  ph_re, N);
        chk("long_pvd_count", ph_pvd, N);
        chk("long_err",       int'(frame_err), 1);
        step(0, 0, 0, 1, 1);
        chk("long_rc_mode", int'(seg_mode), 0);
        chk("long_rc_err",  int'(frame_err), 0);
        chk("long_rc_bgv",  int'(bg_valid), 0);

        // recapture with frame_start while a background is held
        run_frame(1, N);
        chk("pre_sim_bgv", int'(bg_valid), 1);
        step(0, 1, 1, 1, 1);
        chk("sim_mode", int'(seg_mode), 2);
        chk("sim_bgv",  int'(bg_valid), 0);
        chk("sim_pix0", int'(bg_waddr), 0);

        // Reset mid-frame
        send_pixels(100);
        step(1, 0, 1, 1, 0);
        chk("mid_rst_mode", int'(seg_mode), 0);
        chk("mid_rst_we",   int'(bg_we), 0);
        chk("mid_rst_pvd",  int'(pix_valid_d), 0);
        chk("mid_rst_err",  int'(frame_err), 0);

        // Random soup: frequent frame starts (mostly short frames)
        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 59) == 0));
        // Random soup: sparse frame starts so frames complete and overrun
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 999) == 0), 1'($urandom_range(0, 299) == 0),
                 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 499) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
